// File: rtl/event_blinker.sv
// ============================================================================
//  Module   : event_blinker
//  Purpose  : Queues single-cycle events and turns each one into a
//             human-visible ON/GAP blink timed by a slow-tick divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module event_blinker #(
    parameter int CLK_DIV   = 500_000,
    parameter int ON_TICKS  = 1,
    parameter int GAP_TICKS = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             ovf_clr,
    output logic             led_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int T_MAX  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TICK_W = $clog2(T_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]  PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                start;
    logic                accept;

    assign tick   = (div_cnt == DIV_LAST);
    assign start  = (state == IDLE) && (pending != '0);
    // An event is only lost when the queue is full and nothing leaves it.
    assign accept = evt_in && !start;
    assign busy   = (state != IDLE) || (pending != '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            led_out  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            if (accept) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + CNT_W'(1);
                end
            end else if (!evt_in && start) begin
                pending <= pending - CNT_W'(1);
            end

            if (accept && (pending == PEND_MAX)) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ON;
                        led_out  <= 1'b1;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end
                end
                ON: begin
                    if (tick) begin
                        if (tick_cnt == ON_LAST) begin
                            state    <= GAP;
                            led_out  <= 1'b0;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (tick_cnt == GAP_LAST) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    led_out  <= 1'b0;
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_event_blinker.sv
// ============================================================================
//  Module   : tb_event_blinker
//  Purpose  : Directed, cycle-indexed scoreboard bench for event_blinker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_event_blinker;

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       evt_in  = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    event_blinker #(
        .CLK_DIV  (4),
        .ON_TICKS (2),
        .GAP_TICKS(1),
        .CNT_W    (2)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .evt_in  (evt_in),
        .ovf_clr (ovf_clr),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int led;
        int pend;
        int ovf;
        int bsy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0;

    // -1 in any field means "don't care" for that cycle.
    task automatic push(input int c, input int l, input int p, input int o, input int b);
        exp_t e;
        e.cyc = c; e.led = l; e.pend = p; e.ovf = o; e.bsy = b;
        sb.push_back(e);
    endtask

    task automatic push_led(input int c0, input int c1, input int l);
        for (int c = c0; c <= c1; c++) push(t0 + c, l, -1, -1, -1);
    endtask

    task automatic chk(input string name, input int act, input int exp, input int c);
        if (exp >= 0) begin
            n_cmp++;
            if (act != exp) begin
                n_bad++;
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_in);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk("led_out",  int'(led_out),  sb[i].led,  cyc);
                    chk("pending",  int'(pending),  sb[i].pend, cyc);
                    chk("overflow", int'(overflow), sb[i].ovf,  cyc);
                    chk("busy",     int'(busy),     sb[i].bsy,  cyc);
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stale_expect: cycle %0d never checked (now %0d)", sb[i].cyc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic drive(input logic [63:0] ev, input logic [63:0] cl,
                         input logic [63:0] rl, input int n);
        for (int k = 0; k < n; k++) begin
            evt_in  = ev[k];
            ovf_clr = cl[k];
            rst_n   = !rl[k];
            @(negedge clk_in);
        end
        evt_in  = 1'b0;
        ovf_clr = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk_in);
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL drain_timeout: busy got 1, expected 0");
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state
        @(negedge clk_in);
        t0 = cyc;
        push(t0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Single event: latency and blink window
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 0, 0, 0, 0, 0);
        push(t0 + 1, 0, 1, 0, 1);
        push(t0 + 2, 1, 0, -1, 1);
        push_led(3, 9, 1);
        push(t0 + 10, 0, 0, -1, 1);
        push_led(11, 13, 0);
        push(t0 + 14, 0, 0, 0, 0);
        drive(64'h1, 64'h0, 64'h0, 15);
        drain();

        // Events at 0 and 3: second queues during the first blink
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 1, 0, 1, -1, 1);
        push(t0 + 2, 1, 0, -1, 1);
        for (int c = 4; c <= 14; c++) push(t0 + c, -1, 1, -1, 1);
        push(t0 + 9, 1, -1, -1, -1);
        push(t0 + 10, 0, -1, -1, -1);
        push(t0 + 14, 0, -1, -1, -1);
        push(t0 + 15, 1, 0, -1, 1);
        push(t0 + 22, 1, -1, -1, -1);
        push(t0 + 23, 0, -1, -1, 1);
        push(t0 + 27, 0, 0, 0, 0);
        drive(64'h9, 64'h0, 64'h0, 28);
        drain();

        // Four back-to-back pulses: the second coincides with the decrement
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 1, -1, 1, 0, -1);
        push(t0 + 2, 1, 1, 0, -1);
        push(t0 + 3, -1, 2, 0, -1);
        push(t0 + 4, -1, 3, 0, -1);
        push(t0 + 14, 0, 3, 0, 1);
        push(t0 + 15, 1, 2, 0, 1);
        drive(64'hF, 64'h0, 64'h0, 16);
        drain();

        // Saturation drop, clear, set-wins-over-clear, saturated+decrement
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 4, 1, 3, 0, 1);
        push(t0 + 5, -1, 3, 0, -1);
        push(t0 + 6, -1, 3, 1, -1);
        push(t0 + 7, -1, 3, 1, -1);
        push(t0 + 8, 1, 3, 0, -1);
        push(t0 + 9, 1, 3, 1, -1);
        push(t0 + 10, 0, 3, 0, 1);
        push(t0 + 14, 0, 3, 0, 1);
        push(t0 + 15, 1, 3, 0, 1);
        drive(64'h412F, 64'h380, 64'h0, 16);
        drain();

        // Reset mid-blink with two queued, then a fresh event
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 3, 1, 2, -1, 1);
        push(t0 + 4, 1, 2, 0, 1);
        push(t0 + 5, 0, 0, 0, 0);
        push(t0 + 6, 0, 0, 0, 0);
        push(t0 + 7, 0, 0, 0, 0);
        push(t0 + 8, 0, 0, 0, 0);
        push(t0 + 9, 0, 1, 0, 1);
        push(t0 + 10, 1, 0, -1, 1);
        push_led(11, 17, 1);
        push_led(18, 21, 0);
        push(t0 + 22, 0, 0, 0, 0);
        drive(64'h147, 64'h0, 64'h60, 23);
        drain();

        // Event held three cycles -> three blinks
        @(negedge clk_in);
        t0 = cyc;
        push(t0 + 1, -1, 1, -1, -1);
        push(t0 + 2, 1, 1, -1, -1);
        push(t0 + 3, 1, 2, -1, -1);
        push(t0 + 14, 0, 2, -1, 1);
        push(t0 + 15, 1, 1, -1, 1);
        push(t0 + 27, 0, 1, -1, 1);
        push(t0 + 28, 1, 0, -1, 1);
        push(t0 + 35, 1, -1, -1, -1);
        push(t0 + 36, 0, 0, -1, 1);
        push(t0 + 40, 0, 0, 0, 0);
        drive(64'h7, 64'h0, 64'h0, 41);
        drain();

        repeat (3) @(negedge clk_in);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expect: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
